// File: rtl/pe_cntl_pkg.sv
// pe_cntl_pkg: shared FSM state, stream request type and counter-width helper for the PE layer sequencer
package pe_cntl_pkg;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
  localparam int NUM_LAYERS_DEF = 4;
  localparam int MAX_FILTERS_DEF = 64;
  localparam int K_GROUP_DEF = 4;
  localparam int PE_ID_W = 8;
  localparam int LW_DEF = cnt_w(NUM_LAYERS_DEF);
  localparam int KW_DEF = cnt_w(MAX_FILTERS_DEF);
  localparam int GW_DEF = cnt_w(K_GROUP_DEF);
  typedef enum logic [3:0] {
    IDLE, CHECK, REQ, WAIT_STREAM, EXEC, WAIT_EXEC, PPU, WAIT_PPU, NEXT
  } pe_seq_state_e;
  typedef struct packed {
    logic [PE_ID_W-1:0] pe_id;
    logic [LW_DEF-1:0] layer;
    logic [KW_DEF-1:0] k_base;
    logic [GW_DEF-1:0] k_cnt;
    logic want_input;
  } req_stream_t;
endpackage

// File: rtl/pe_group_counter.sv
// pe_group_counter: filter-group base register, clamped group size (min of K_GROUP and remainder) and last-group flag
module pe_group_counter import pe_cntl_pkg::*; #(
  parameter int MAX_FILTERS = MAX_FILTERS_DEF,
  parameter int K_GROUP = K_GROUP_DEF,
  localparam int KW = cnt_w(MAX_FILTERS),
  localparam int GW = cnt_w(K_GROUP)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic adv_i,
  input  logic [KW-1:0] num_k_i,
  output logic [KW-1:0] k_base_o,
  output logic [GW-1:0] k_cnt_o,
  output logic last_o
);
  logic [KW-1:0] k_base_q, k_base_d, num_k, rem;
  logic [KW:0] sum;
  always_comb begin
    num_k = (num_k_i > KW'(MAX_FILTERS)) ? KW'(MAX_FILTERS) : num_k_i;
    rem = (num_k > k_base_q) ? num_k - k_base_q : '0;
    k_cnt_o = (rem > KW'(K_GROUP)) ? GW'(K_GROUP) : GW'(rem);
    sum = {1'b0, k_base_q} + {{(KW + 1 - GW){1'b0}}, k_cnt_o};
    last_o = sum >= {1'b0, num_k};
    k_base_d = clr_i ? '0 : adv_i ? sum[KW-1:0] : k_base_q;
  end
  always_ff @(posedge clk) k_base_q <= rst ? '0 : k_base_d;
  assign k_base_o = k_base_q;
endmodule

// File: rtl/pe_layer_sequencer.sv
// pe_layer_sequencer: per-PE FSM walking conv layers and their filter groups through request, stream, exec and PPU phases
module pe_layer_sequencer import pe_cntl_pkg::*; #(
  parameter int NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int MAX_FILTERS = MAX_FILTERS_DEF,
  parameter int K_GROUP = K_GROUP_DEF,
  parameter int PE_ID = 0,
  localparam int LW = cnt_w(NUM_LAYERS),
  localparam int KW = cnt_w(MAX_FILTERS),
  localparam int GW = cnt_w(K_GROUP)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic [LW-1:0] cfg_num_layers,
  output logic [LW-1:0] cur_layer,
  input  logic [KW-1:0] layer_num_k,
  output req_stream_t req,
  output logic req_valid,
  input  logic req_ready,
  input  logic stream_done,
  output logic exec_start,
  input  logic exec_done,
  output logic ppu_start,
  input  logic ppu_done,
  output logic busy,
  output logic run_done
);
  pe_seq_state_e state_q, state_d;
  logic [LW-1:0] cur_layer_q, cur_layer_d, num_layers_q, num_layers_d;
  logic run_done_q, run_done_d, clr, adv, last, final_layer;
  logic [KW-1:0] k_base;
  logic [GW-1:0] k_cnt;
  pe_group_counter #(.MAX_FILTERS(MAX_FILTERS), .K_GROUP(K_GROUP)) u_grp (
    .clk(clk), .rst(rst), .clr_i(clr), .adv_i(adv), .num_k_i(layer_num_k),
    .k_base_o(k_base), .k_cnt_o(k_cnt), .last_o(last)
  );
  assign final_layer = ({1'b0, cur_layer_q} + (LW + 1)'(1)) == {1'b0, num_layers_q};
  always_comb begin
    state_d = state_q;
    cur_layer_d = cur_layer_q;
    num_layers_d = num_layers_q;
    run_done_d = 1'b0;
    clr = 1'b0;
    adv = 1'b0;
    if (abort) begin
      state_d = IDLE;
      cur_layer_d = '0;
      clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          num_layers_d = cfg_num_layers;
          run_done_d = cfg_num_layers == '0;
          state_d = (cfg_num_layers == '0) ? IDLE : CHECK;
          cur_layer_d = '0;
          clr = 1'b1;
        end
        CHECK: state_d = (layer_num_k == '0) ? NEXT : REQ;
        REQ: state_d = req_ready ? WAIT_STREAM : REQ;
        WAIT_STREAM: state_d = stream_done ? EXEC : WAIT_STREAM;
        EXEC: state_d = WAIT_EXEC;
        WAIT_EXEC: if (exec_done) begin
          adv = 1'b1;
          state_d = last ? PPU : REQ;
        end
        PPU: state_d = WAIT_PPU;
        WAIT_PPU: state_d = ppu_done ? NEXT : WAIT_PPU;
        NEXT: begin
          run_done_d = final_layer;
          state_d = final_layer ? IDLE : CHECK;
          cur_layer_d = final_layer ? '0 : cur_layer_q + LW'(1);
          clr = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    cur_layer_q <= rst ? '0 : cur_layer_d;
    num_layers_q <= rst ? '0 : num_layers_d;
    run_done_q <= rst ? 1'b0 : run_done_d;
  end
  assign cur_layer = cur_layer_q;
  assign req_valid = state_q == REQ;
  assign exec_start = state_q == EXEC;
  assign ppu_start = state_q == PPU;
  assign busy = state_q != IDLE;
  assign run_done = run_done_q;
  assign req = (state_q == IDLE) ? '0 : req_stream_t'{
    pe_id: PE_ID_W'(PE_ID), layer: cur_layer_q, k_base: k_base, k_cnt: k_cnt, want_input: k_base == '0};
endmodule

// File: tb/tb_pe_layer_sequencer.sv
// tb_pe_layer_sequencer: randomized self-checking bench against a queue-based model of the layer/group walk
module tb_pe_layer_sequencer;
  import pe_cntl_pkg::*;
  localparam int NL = 4, MF = 64, KG = 4, PID = 5;
  localparam int LW = cnt_w(NL), KW = cnt_w(MF), GW = cnt_w(KG);
  logic clk = 1'b0;
  logic rst, start, abort, req_ready, stream_done, exec_done, ppu_done;
  logic req_valid, exec_start, ppu_start, busy, run_done;
  logic [LW-1:0] cfg_num_layers, cur_layer;
  logic [KW-1:0] layer_num_k;
  logic [KW-1:0] k_tbl [8];
  req_stream_t req;
  req_stream_t exp_q [$];
  logic [LW+KW-1:0] ppu_q [$];
  int vectors = 0, miscompares = 0;
  pe_layer_sequencer #(.NUM_LAYERS(NL), .MAX_FILTERS(MF), .K_GROUP(KG), .PE_ID(PID)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_num_layers(cfg_num_layers),
    .cur_layer(cur_layer), .layer_num_k(layer_num_k), .req(req), .req_valid(req_valid),
    .req_ready(req_ready), .stream_done(stream_done), .exec_start(exec_start), .exec_done(exec_done),
    .ppu_start(ppu_start), .ppu_done(ppu_done), .busy(busy), .run_done(run_done)
  );
  always #5 clk = ~clk;
  assign layer_num_k = k_tbl[cur_layer];
  function automatic void build(input int nl);
    exp_q.delete();
    ppu_q.delete();
    for (int l = 0; l < nl; l++) begin
      int k;
      k = (int'(k_tbl[l]) > MF) ? MF : int'(k_tbl[l]);
      for (int b = 0; b < k; b += KG)
        exp_q.push_back(req_stream_t'{pe_id: PE_ID_W'(PID), layer: LW'(l), k_base: KW'(b),
          k_cnt: GW'((k - b < KG) ? k - b : KG), want_input: b == 0});
      if (k > 0) ppu_q.push_back({LW'(l), KW'(k)});
    end
  endfunction
  task automatic idle_inputs;
    start = 1'b0;
    abort = 1'b0;
    req_ready = 1'b0;
    stream_done = 1'b0;
    exec_done = 1'b0;
    ppu_done = 1'b0;
  endtask
  task automatic do_run(input int nl, input int rdy_pct, input int stall, input bit poke, input int dmax);
    int sd = 0, ed = 0, pd = 0, stalled = 0, execs = 0, nreq, cyc = 0;
    bit held = 0, poked = 0, done = 0;
    req_stream_t last_req, e;
    logic [LW-1:0] last_layer;
    logic [LW+KW-1:0] pe;
    build(nl);
    nreq = exp_q.size();
    @(negedge clk);
    idle_inputs();
    cfg_num_layers = LW'(nl);
    start = 1'b1;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      idle_inputs();
      stream_done = (sd == 1);
      exec_done = (ed == 1);
      ppu_done = (pd == 1);
      sd = (sd > 0) ? sd - 1 : 0;
      ed = (ed > 0) ? ed - 1 : 0;
      pd = (pd > 0) ? pd - 1 : 0;
      if (poked) begin
        vectors++;
        if (cur_layer !== last_layer) begin
          miscompares++;
          $display("FAIL busy_start: cur_layer got %0d exp %0d", cur_layer, last_layer);
        end
        poked = 0;
      end
      vectors++;
      if (busy !== !run_done) begin
        miscompares++;
        $display("FAIL busy: got %b exp %b (run_done %b)", busy, !run_done, run_done);
      end
      if (run_done) done = 1;
      else begin
        if (held) begin
          vectors++;
          if (req_valid !== 1'b1 || req !== last_req) begin
            miscompares++;
            $display("FAIL req_hold: got valid %b req %h exp valid 1 req %h", req_valid, req, last_req);
          end
        end
        held = 0;
        if (req_valid) begin
          req_ready = (stalled < stall) ? 1'b0 : (int'($urandom_range(99)) < rdy_pct);
          if (req_ready) begin
            stalled = 0;
            vectors++;
            if (exp_q.size() == 0) begin
              miscompares++;
              $display("FAIL req_extra: got %h exp no request", req);
            end else begin
              e = exp_q.pop_front();
              if (req !== e) begin
                miscompares++;
                $display("FAIL req: got %h exp %h", req, e);
              end
            end
            sd = 1 + int'($urandom_range(dmax));
          end else begin
            stalled++;
            held = 1;
            last_req = req;
            if (poke) begin
              start = 1'b1;
              cfg_num_layers = LW'($urandom);
              stream_done = 1'b1;
              exec_done = 1'b1;
              ppu_done = 1'b1;
              poked = 1;
              last_layer = cur_layer;
            end
          end
        end
        if (exec_start) begin
          execs++;
          ed = 1 + int'($urandom_range(dmax));
        end
        if (ppu_start) begin
          vectors++;
          pe = (ppu_q.size() > 0) ? ppu_q.pop_front() : '1;
          if ({req.layer, req.k_base} !== pe) begin
            miscompares++;
            $display("FAIL ppu: got layer/k_base %h exp %h", {req.layer, req.k_base}, pe);
          end
          pd = 1 + int'($urandom_range(dmax));
        end
      end
    end
    if (!done) begin
      miscompares++;
      $display("FAIL run_timeout: got no run_done in %0d cycles exp run_done", cyc);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    vectors++;
    if (exp_q.size() != 0 || ppu_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing: got %0d reqs %0d ppus left exp 0 0", exp_q.size(), ppu_q.size());
    end
    vectors++;
    if (execs != nreq) begin
      miscompares++;
      $display("FAIL exec_count: got %0d exp %0d", execs, nreq);
    end
    idle_inputs();
  endtask
  task automatic test_reset;
    idle_inputs();
    cfg_num_layers = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({req_valid, exec_start, ppu_start, busy, run_done} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b exp 00000", {req_valid, exec_start, ppu_start, busy, run_done});
    end
    vectors++;
    if (cur_layer !== '0 || req !== '0) begin
      miscompares++;
      $display("FAIL reset_req: got layer %0d req %h exp 0 0", cur_layer, req);
    end
    rst = 1'b0;
  endtask
  task automatic test_single_layer;
    k_tbl[0] = 8;
    do_run(1, 100, 0, 0, 0);
  endtask
  task automatic test_partial_group;
    k_tbl[0] = 10;
    do_run(1, 100, 0, 0, 2);
  endtask
  task automatic test_ready_stall;
    k_tbl[0] = 8;
    do_run(1, 100, 5, 1, 1);
  endtask
  task automatic test_empty_layer;
    k_tbl[0] = 5;
    k_tbl[1] = 0;
    k_tbl[2] = 3;
    do_run(3, 70, 0, 0, 2);
  endtask
  task automatic test_abort;
    int n = 0;
    k_tbl[0] = 0;
    k_tbl[1] = 8;
    @(negedge clk);
    idle_inputs();
    cfg_num_layers = LW'(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    req_ready = 1'b1;
    stream_done = 1'b1;
    while (!exec_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (exec_start !== 1'b1 || cur_layer !== LW'(1)) begin
      miscompares++;
      $display("FAIL abort_setup: got exec_start %b layer %0d exp 1 1", exec_start, cur_layer);
    end
    req_ready = 1'b0;
    stream_done = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    exec_done = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++;
    if ({busy, req_valid, exec_start, ppu_start, run_done} !== 5'b0) begin
      miscompares++;
      $display("FAIL abort_ctl: got %b exp 00000", {busy, req_valid, exec_start, ppu_start, run_done});
    end
    vectors++;
    if (cur_layer !== '0 || req !== '0) begin
      miscompares++;
      $display("FAIL abort_req: got layer %0d req %h exp 0 0", cur_layer, req);
    end
    @(negedge clk);
    exec_done = 1'b0;
    vectors++;
    if ({busy, req_valid, exec_start, ppu_start, run_done} !== 5'b0) begin
      miscompares++;
      $display("FAIL abort_stray: got %b exp 00000", {busy, req_valid, exec_start, ppu_start, run_done});
    end
    k_tbl[0] = 4;
    do_run(2, 100, 0, 0, 1);
  endtask
  task automatic test_empty_run;
    @(negedge clk);
    idle_inputs();
    cfg_num_layers = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (run_done !== 1'b1) begin
      miscompares++;
      $display("FAIL empty_done: got %b exp 1", run_done);
    end
    vectors++;
    if ({busy, req_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL empty_idle: got %b exp 00", {busy, req_valid});
    end
    @(negedge clk);
    vectors++;
    if (run_done !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_pulse: got %b exp 0", run_done);
    end
  endtask
  task automatic test_back_to_back;
    k_tbl[0] = 64;
    k_tbl[1] = 1;
    k_tbl[2] = 127;
    k_tbl[3] = 4;
    do_run(4, 100, 0, 0, 0);
    do_run(2, 100, 0, 0, 0);
  endtask
  task automatic test_random;
    for (int r = 0; r < 12; r++) begin
      for (int l = 0; l < 8; l++) k_tbl[l] = ($urandom_range(3) == 0) ? '0 : KW'($urandom_range(127, 1));
      do_run(int'($urandom_range(NL, 1)), 60, int'($urandom_range(2)), 1'b1, 3);
    end
  endtask
  initial begin
    for (int i = 0; i < 8; i++) k_tbl[i] = '0;
    test_reset();
    test_single_layer();
    test_partial_group();
    test_ready_stall();
    test_empty_layer();
    test_abort();
    test_empty_run();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
